// File: rtl/cp0_exc_handler.sv
// CP0 exception/interrupt sink at the end of the M stage.
// Ports: clk, reset (sync, active-low), A1/DOut mfc0, A2/DIn/WE mtc0,
//   PC_M/BD_M/ExcCode_M/HWInt/EXLClr event inputs, IntReq, EPC_out.
module cp0_exc_handler #(
    parameter logic [31:0] PRID_VAL = 32'h4D495053,
    parameter logic [31:0] EPC_MASK = 32'hFFFFFFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  im;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exccode;
    logic [31:0] epc;

    logic        exl;
    logic        int_pend;
    logic        exc_pend;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] pc_adj;
    logic [31:0] sr;
    logic [31:0] cause;

    assign exl      = (state == HANDLER);
    assign int_pend = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend = (ExcCode_M != 5'd0) & ~exl;
    assign IntReq   = int_pend | exc_pend;
    assign wr_sr    = WE & (A2 == 5'd12);
    assign wr_epc   = WE & (A2 == 5'd14);
    // Delay-slot instructions restart at the branch; wraps modulo 2^32.
    assign pc_adj   = BD_M ? (PC_M - 32'd4) : PC_M;
    assign sr       = {16'b0, im, 8'b0, exl, ie};
    assign cause    = {bd, 15'b0, ip, 3'b0, exccode, 2'b0};
    assign EPC_out  = epc;

    // EXL lives in the state register; mtc0 SR can set or clear it,
    // and eret wins over an mtc0 in the same cycle.
    always_comb begin
        state_nx = state;
        if (IntReq) begin
            state_nx = HANDLER;
        end else begin
            if (wr_sr) begin
                state_nx = DIn[1] ? HANDLER : NORMAL;
            end
            if (EXLClr) begin
                state_nx = NORMAL;
            end
        end
    end

    always_comb begin
        DOut = 32'h0;
        case (A1)
            5'd12:   DOut = sr;
            5'd13:   DOut = cause;
            5'd14:   DOut = epc;
            5'd15:   DOut = PRID_VAL;
            default: DOut = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= NORMAL;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im      <= 6'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= 6'b0;
            exccode <= 5'b0;
            epc     <= 32'h0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exccode <= int_pend ? 5'd0 : ExcCode_M;
                bd      <= BD_M;
                epc     <= pc_adj & EPC_MASK;
            end else if (wr_sr) begin
                im <= DIn[15:10];
                ie <= DIn[0];
            end else if (wr_epc) begin
                epc <= DIn & EPC_MASK;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Scoreboard bench for cp0_exc_handler: per-cycle expectations are
// queued at drive time and compared by a monitor mid-cycle.
module tb_cp0_exc_handler;

    localparam logic [31:0] PRID = 32'h4D495053;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    typedef struct {
        int          cyc;
        bit          en;
        logic        ireq;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;

    cp0_exc_handler dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn),
        .WE(WE), .PC_M(PC_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M),
        .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq),
        .EPC_out(EPC_out), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input logic ei, input logic [31:0] ed,
                        input logic [31:0] ee, input bit en = 1'b1);
        exp_t e;
        e.cyc  = cyc_n;
        e.en   = en;
        e.ireq = ei;
        e.dout = ed;
        e.epc  = ee;
        q.push_back(e);
        cyc_n++;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.en) begin
                chk($sformatf("intreq@%0d", e.cyc), {31'b0, IntReq},
                    {31'b0, e.ireq});
                chk($sformatf("dout@%0d", e.cyc), DOut, e.dout);
                chk($sformatf("epc@%0d", e.cyc), EPC_out, e.epc);
            end
        end
    end

    initial begin
        reset = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0; WE = 1'b0;
        PC_M = 32'h0; BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0;
        EXLClr = 1'b0;
        @(negedge clk);

        // reset and register readback
        step(1'b0, 32'h0, 32'h0, 1'b0);
        A1 = 5'd12;             step(1'b0, 32'h0, 32'h0);
        reset = 1'b1; A1 = 5'd13; step(1'b0, 32'h0, 32'h0);
        A1 = 5'd14;             step(1'b0, 32'h0, 32'h0);
        A1 = 5'd15;             step(1'b0, PRID, 32'h0);

        // interrupt entry
        A1 = 5'd12; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        step(1'b0, 32'h0, 32'h0);
        WE = 1'b0; HWInt = 6'b000001; PC_M = 32'h3010;
        step(1'b1, 32'h401, 32'h0);
        step(1'b0, 32'h403, 32'h3010);
        A1 = 5'd13;             step(1'b0, 32'h400, 32'h3010);
        A1 = 5'd14;             step(1'b0, 32'h3010, 32'h3010);
        A1 = 5'd12; HWInt = 6'd0; EXLClr = 1'b1;
        step(1'b0, 32'h403, 32'h3010);
        EXLClr = 1'b0;          step(1'b0, 32'h401, 32'h3010);

        // synchronous exception in delay slot, then masked in handler
        WE = 1'b1; DIn = 32'h0000_0400;
        step(1'b0, 32'h401, 32'h3010);
        WE = 1'b0; ExcCode_M = 5'd10; BD_M = 1'b1; PC_M = 32'h3024;
        step(1'b1, 32'h400, 32'h3010);
        ExcCode_M = 5'd4; BD_M = 1'b0; PC_M = 32'h4000; A1 = 5'd13;
        step(1'b0, 32'h8000_0028, 32'h3020);
        step(1'b0, 32'h8000_0028, 32'h3020);
        ExcCode_M = 5'd0; EXLClr = 1'b1; A1 = 5'd12;
        step(1'b0, 32'h402, 32'h3020);
        EXLClr = 1'b0;          step(1'b0, 32'h400, 32'h3020);

        // interrupt beats exception and drops the mtc0
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        step(1'b0, 32'h400, 32'h3020);
        A2 = 5'd14; DIn = 32'h5555; HWInt = 6'b000001;
        ExcCode_M = 5'd12; PC_M = 32'h5000;
        step(1'b1, 32'h401, 32'h3020);
        WE = 1'b0; ExcCode_M = 5'd0; A1 = 5'd13;
        step(1'b0, 32'h400, 32'h5000);
        EXLClr = 1'b1; A1 = 5'd12;
        step(1'b0, 32'h403, 32'h5000);
        EXLClr = 1'b0;          step(1'b1, 32'h401, 32'h5000);
        HWInt = 6'd0;           step(1'b0, 32'h403, 32'h5000);
        EXLClr = 1'b1;          step(1'b0, 32'h403, 32'h5000);
        EXLClr = 1'b0;          step(1'b0, 32'h401, 32'h5000);

        // EPC write masking, unmapped read, ignored Cause write
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
        step(1'b0, 32'h401, 32'h5000);
        WE = 1'b0; A1 = 5'd99 & 5'h1f; A1 = 5'd3;
        step(1'b0, 32'h0, 32'h3004);
        WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; A1 = 5'd13;
        step(1'b0, 32'h0, 32'h3004);
        WE = 1'b0;              step(1'b0, 32'h0, 32'h3004);

        // delay slot at PC 0 wraps; leave handler via mtc0 SR
        ExcCode_M = 5'd8; BD_M = 1'b1; PC_M = 32'h0;
        step(1'b1, 32'h0, 32'h3004);
        ExcCode_M = 5'd0; BD_M = 1'b0;
        step(1'b0, 32'h8000_0020, 32'hFFFF_FFFC);
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; A1 = 5'd12;
        step(1'b0, 32'h403, 32'hFFFF_FFFC);
        WE = 1'b0;              step(1'b0, 32'h401, 32'hFFFF_FFFC);

        // reset overrides a pending exception
        ExcCode_M = 5'd5; PC_M = 32'h7000; reset = 1'b0;
        step(1'b1, 32'h401, 32'hFFFF_FFFC);
        reset = 1'b1; ExcCode_M = 5'd0;
        step(1'b0, 32'h0, 32'h0);
        A1 = 5'd13;             step(1'b0, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
